// File: rtl/blk_mem_pkg.sv
// Shared types and constants for the block memory controller.
package blk_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdWait,
    StLdDone,
    StStWait,
    StStDone,
    StStRelease
  } mem_state_t;

  localparam int unsigned DEF_LOAD_LAT  = 3;
  localparam int unsigned DEF_STORE_LAT = 2;
  localparam int unsigned BLK_BYTES     = 4;

endpackage

// File: rtl/blk_mem_ctrl_if.sv
// Cache-side load/store handshake bundle for blk_mem_ctrl.
interface blk_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic              load_req;
  logic              load_rdy;
  logic [DATA_W-1:0] data_out;
  logic              store_req;
  logic              store_done;
  logic              store_ack;
  logic              busy;

  modport master (
    output addr_in, data_in, load_req, store_req, store_ack,
    input  load_rdy, data_out, store_done, busy
  );

  modport slave (
    input  addr_in, data_in, load_req, store_req, store_ack,
    output load_rdy, data_out, store_done, busy
  );
endinterface

// File: rtl/blk_ram.sv
// Single-port block RAM with synchronous write and registered read data.
module blk_ram #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/blk_mem_ctrl.sv
// Memory-side controller behind the L1 D-cache: serialized block loads/stores with
// programmable latency over a 4-phase req/ack handshake.
module blk_mem_ctrl
  import blk_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LOAD_LAT   = DEF_LOAD_LAT,
  parameter int unsigned STORE_LAT  = DEF_STORE_LAT
) (
  input logic           clk,
  input logic           rst,
  blk_mem_ctrl_if.slave bus
);

  localparam int unsigned IdxLsb = $clog2(BLK_BYTES);
  localparam int unsigned MaxLat = (LOAD_LAT > STORE_LAT) ? LOAD_LAT : STORE_LAT;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

  if (LOAD_LAT == 0) begin : g_load_lat_chk
    $error("LOAD_LAT must be at least 1");
  end
  if (STORE_LAT == 0) begin : g_store_lat_chk
    $error("STORE_LAT must be at least 1");
  end

  mem_state_t            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;
  logic                  load_rdy_q, load_rdy_d;
  logic                  store_done_q, store_done_d;
  logic                  busy_q;

  logic [DEPTH_LOG2-1:0] addr_idx;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  ram_we;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  unused_addr;

  assign addr_idx    = bus.addr_in[IdxLsb +: DEPTH_LOG2];
  assign unused_addr = ^{bus.addr_in[ADDR_W-1:IdxLsb+DEPTH_LOG2], bus.addr_in[IdxLsb-1:0]};

  blk_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .idx  (ram_idx),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    data_out_d   = data_out_q;
    load_rdy_d   = load_rdy_q;
    store_done_d = store_done_q;
    ram_we       = 1'b0;
    ram_idx      = idx_q;

    unique case (state_q)
      StIdle: begin
        // Read from the live address so registered rdata is ready even for LOAD_LAT=1.
        ram_idx = addr_idx;
        if (bus.store_req) begin
          idx_d   = addr_idx;
          wdata_d = bus.data_in;
          cnt_d   = CntW'(STORE_LAT - 1);
          state_d = StStWait;
        end else if (bus.load_req) begin
          idx_d   = addr_idx;
          cnt_d   = CntW'(LOAD_LAT - 1);
          state_d = StLdWait;
        end
      end
      StLdWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_out_d = ram_rdata;
          load_rdy_d = 1'b1;
          state_d    = StLdDone;
        end
      end
      StLdDone: begin
        if (!bus.load_req) begin
          load_rdy_d = 1'b0;
          state_d    = StIdle;
        end
      end
      StStWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ram_we       = 1'b1;
          store_done_d = 1'b1;
          state_d      = StStDone;
        end
      end
      StStDone: begin
        if (bus.store_ack) begin
          store_done_d = 1'b0;
          state_d      = StStRelease;
        end
      end
      StStRelease: begin
        // Ack must drop before the next request so a stale ack can't complete it.
        if (!bus.store_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      data_out_q   <= '0;
      load_rdy_q   <= 1'b0;
      store_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      data_out_q   <= data_out_d;
      load_rdy_q   <= load_rdy_d;
      store_done_q <= store_done_d;
      busy_q       <= (state_d != StIdle);
    end
  end

  assign bus.load_rdy   = load_rdy_q;
  assign bus.data_out   = data_out_q;
  assign bus.store_done = store_done_q;
  assign bus.busy       = busy_q;

endmodule
